modexp_controller: RTL and testbench

Sequencer that computes base^exponent mod modulus by driving one Montgomery multiplier (A·B·2^-BITS mod M, go/done handshake) through left-to-right square-and-multiply in the Montgomery domain. It sits between the RSA work-distribution front end and the multiplier datapath. It owns operand selection, the multiplier handshake, exponent scanning and final reduction.

---
 rtl/modexp_pkg.sv | 28 ++
 rtl/modexp_msb_finder.sv | 24 ++
 rtl/modexp_controller.sv | 183 ++++++++++++++++++
 tb/tb_modexp_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM state codes,
// multiplier operation selector and default operand width.
package modexp_pkg;

  localparam int BITS_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CHECK = 3'd1;
  localparam state_t S_MUL   = 3'd2;
  localparam state_t S_GAP   = 3'd3;
  localparam state_t S_FIX   = 3'd4;
  localparam state_t S_FIN   = 3'd5;

  typedef enum logic [2:0] {
    OP_TO_MONT_X,
    OP_TO_MONT_ONE,
    OP_SQ,
    OP_MULX,
    OP_FROM_MONT
  } op_t;

  function automatic int idx_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/modexp_msb_finder.sv
// Combinational highest-set-bit encoder with an all-zero flag; used to skip
// leading zero exponent bits when MODEXP_SKIP_LEADING_ZEROS_EN is defined.
module modexp_msb_finder
  import modexp_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic [BITS-1:0]           value,
  output logic [idx_width(BITS)-1:0] msb,
  output logic                      zero
);

  localparam int IW = idx_width(BITS);

  always_comb begin
    msb  = '0;
    zero = (value == '0);
    // Later (higher) set bits overwrite earlier ones.
    for (int i = 0; i < BITS; i++) begin
      if (value[i]) msb = IW'(i);
    end
  end

endmodule

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN starts the scan at the exponent's top set bit.
module modexp_controller
  import modexp_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] base,
  input  logic [BITS-1:0] exponent,
  input  logic [BITS-1:0] modulus,
  input  logic [BITS-1:0] r2,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [BITS-1:0] result,
  output logic [BITS-1:0] mm_a,
  output logic [BITS-1:0] mm_b,
  output logic [BITS-1:0] mm_m,
  output logic            mm_go,
  input  logic            mm_done,
  input  logic [BITS-1:0] mm_s
);

  localparam int IW = idx_width(BITS);
  localparam logic [BITS-1:0] MONT_ONE = BITS'(1);

  state_t          state;
  op_t             op, nxt_op, opnd_op;
  logic [IW-1:0]   idx, nxt_idx, scan_top;
  logic            scan_empty, ops_done;
  logic [BITS-1:0] base_r, exp_r, mod_r, r2_r;
  logic [BITS-1:0] acc, xbar, opnd_a, opnd_b;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [IW-1:0] msb;
  logic          exp_zero;

  modexp_msb_finder #(.BITS(BITS)) u_msb (
    .value (exp_r),
    .msb   (msb),
    .zero  (exp_zero)
  );

  assign scan_top   = msb;
  assign scan_empty = exp_zero;
`else
  assign scan_top   = IW'(BITS - 1);
  assign scan_empty = 1'b0;
`endif

  // Successor of the op that just finished (evaluated in GAP).
  always_comb begin
    nxt_op   = op;
    nxt_idx  = idx;
    ops_done = 1'b0;
    case (op)
      OP_TO_MONT_X:   nxt_op = OP_TO_MONT_ONE;
      OP_TO_MONT_ONE: nxt_op = scan_empty ? OP_FROM_MONT : OP_SQ;
      OP_SQ: begin
        if (exp_r[idx]) begin
          nxt_op = OP_MULX;
        end else if (idx == '0) begin
          nxt_op = OP_FROM_MONT;
        end else begin
          nxt_op  = OP_SQ;
          nxt_idx = idx - 1'b1;
        end
      end
      OP_MULX: begin
        if (idx == '0) begin
          nxt_op = OP_FROM_MONT;
        end else begin
          nxt_op  = OP_SQ;
          nxt_idx = idx - 1'b1;
        end
      end
      default: ops_done = 1'b1;
    endcase
  end

  // CHECK launches the first op itself; GAP launches the successor.
  assign opnd_op = (state == S_CHECK) ? op : nxt_op;

  always_comb begin
    opnd_a = acc;
    opnd_b = acc;
    case (opnd_op)
      OP_TO_MONT_X:   begin opnd_a = base_r;   opnd_b = r2_r;     end
      OP_TO_MONT_ONE: begin opnd_a = MONT_ONE; opnd_b = r2_r;     end
      OP_SQ:          begin opnd_a = acc;      opnd_b = acc;      end
      OP_MULX:        begin opnd_a = acc;      opnd_b = xbar;     end
      default:        begin opnd_a = acc;      opnd_b = MONT_ONE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op     <= OP_TO_MONT_X;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mm_go  <= 1'b0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_m   <= '0;
      acc    <= '0;
      xbar   <= '0;
      base_r <= '0;
      exp_r  <= '0;
      mod_r  <= '0;
      r2_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exponent;
            mod_r  <= modulus;
            r2_r   <= r2;
            idx    <= IW'(BITS - 1);
            op     <= OP_TO_MONT_X;
            busy   <= 1'b1;
            err    <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!mod_r[0]) begin
            err    <= 1'b1;
            result <= '0;
            state  <= S_FIN;
          end else begin
            idx   <= scan_top;
            mm_a  <= opnd_a;
            mm_b  <= opnd_b;
            mm_m  <= mod_r;
            mm_go <= 1'b1;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (mm_done) begin
            if (op == OP_TO_MONT_X) xbar <= mm_s;
            else                    acc  <= mm_s;
            mm_go <= 1'b0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (ops_done) begin
            state <= S_FIX;
          end else begin
            op    <= nxt_op;
            idx   <= nxt_idx;
            mm_a  <= opnd_a;
            mm_b  <= opnd_b;
            mm_go <= 1'b1;
            state <= S_MUL;
          end
        end
        S_FIX: begin
          // Multiplier output may sit in [M, 2M); one subtract normalises it.
          result <= (acc >= mod_r) ? acc - mod_r : acc;
          state  <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_controller.sv
// Self-checking bench: behavioural Montgomery multiplier plus plain-arithmetic
// modexp reference; directed cases followed by 200 randomized requests.
module tb_modexp_controller;

  localparam int BITS = 8;
  localparam int OPLAT = BITS + 3;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] base, exponent, modulus, r2;
  logic       busy, done, err;
  logic [7:0] result, mm_a, mm_b, mm_m;
  logic       mm_go, mm_done;
  logic [7:0] mm_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  modexp_controller #(.BITS(BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .r2       (r2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_m     (mm_m),
    .mm_go    (mm_go),
    .mm_done  (mm_done),
    .mm_s     (mm_s)
  );

  // Multiplier model: done after BITS+1 go-high cycles; result sometimes left in [M,2M).
  int   mcnt = 0;
  int   mx;
  logic extra = 1'b0;

  function automatic int mont(input int a, input int b, input int m);
    for (int x = 0; x < m; x++)
      if ((x * 256) % m == (a * b) % m) return x;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!mm_go) begin
      mcnt  <= 0;
      extra <= 1'($urandom_range(0, 1));
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always_comb begin
    mx = mont(int'(mm_a), int'(mm_b), int'(mm_m));
    if (extra && (mx + int'(mm_m) < 256)) mx = mx + int'(mm_m);
    mm_done = mm_go && (mcnt == BITS + 1);
    mm_s    = mm_done ? 8'(mx) : 8'(mcnt * 37 + 5);
  end

  function automatic int ref_modexp(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int ref_ops(input int e);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    return 3 + $clog2(e + 1) + $countones(e);
`else
    return 3 + BITS + $countones(e);
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One request; inj >= 0 pulses a conflicting start that many cycles in.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input logic [7:0] rr, input int inj,
                        output int res, output int er, output int lat,
                        output int rises, output int badgaps, output int fin);
    logic prev;
    int   lowrun;
    bit   seen;
    @(negedge clk);
    base = b; exponent = e; modulus = m; r2 = rr; start = 1'b1;
    @(posedge clk);
    lat = 0; rises = 0; badgaps = 0; lowrun = 0; seen = 0; fin = 0;
    prev = 1'b0; res = -1; er = -1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (lat == inj) begin
        base = 8'd5; exponent = 8'd200; modulus = 8'd11; r2 = 8'd3; start = 1'b1;
      end
      if (mm_go && !prev) begin
        rises++;
        if (seen && lowrun != 1) badgaps++;
      end
      if (!mm_go && prev) begin seen = 1; lowrun = 0; end
      if (!mm_go) lowrun++;
      prev = mm_go;
      if (done) begin
        fin = 1; res = int'(result); er = int'(err);
        break;
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int res, er, lat, rises, badgaps, fin, cnt;
    reset = 1'b1; start = 1'b0;
    base = '0; exponent = '0; modulus = '0; r2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_err",    int'(err),    0);
    check("rst_go",     int'(mm_go),  0);
    check("rst_result", int'(result), 0);
    check("rst_mm_a",   int'(mm_a),   0);
    check("rst_mm_m",   int'(mm_m),   0);
    reset = 1'b0;

    // 3^5 mod 13
    run_op(8'd3, 8'd5, 8'd13, 8'd3, -1, res, er, lat, rises, badgaps, fin);
    check("d1_done", fin, 1);
    check("d1_res", res, 9);
    check("d1_err", er, 0);
    check("d1_lat", lat, 3 + ref_ops(5) * OPLAT);
    check("d1_ops", rises, ref_ops(5));
    check("d1_gaps", badgaps, 0);
    @(negedge clk);
    check("d1_busy_after", int'(busy), 0);
    check("d1_done_pulse", int'(done), 0);

    // exponent 0: no MULX ops at all
    run_op(8'd7, 8'd0, 8'd13, 8'd3, -1, res, er, lat, rises, badgaps, fin);
    check("e0_res", res, 1);
    check("e0_ops", rises, ref_ops(0));
    check("e0_lat", lat, 3 + ref_ops(0) * OPLAT);

    // even modulus rejected
    run_op(8'd3, 8'd5, 8'd12, 8'd4, -1, res, er, lat, rises, badgaps, fin);
    check("ev_err", er, 1);
    check("ev_res", res, 0);
    check("ev_lat", lat, 2);
    check("ev_go", rises, 0);

    // M=1 gives 0
    run_op(8'd0, 8'd9, 8'd1, 8'd0, -1, res, er, lat, rises, badgaps, fin);
    check("m1_res", res, 0);

    // start while busy is ignored
    run_op(8'd3, 8'd5, 8'd13, 8'd3, 20, res, er, lat, rises, badgaps, fin);
    check("ign_res", res, 9);
    check("ign_lat", lat, 3 + ref_ops(5) * OPLAT);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("ign_no_second", cnt, 0);

    // reset during the third MUL
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd13; r2 = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < 3; c++) begin
      @(negedge clk);
      if (mm_go && mm_done == 1'b0 && mcnt == 0) cnt++;
    end
    check("rst_mid_reached", cnt, 3);
    repeat (3) @(negedge clk);
    check("rst_mid_go_before", int'(mm_go), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_go", int'(mm_go), 0);
    check("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("rst_mid_no_done", cnt, 0);
    run_op(8'd2, 8'd13, 8'd13, 8'd3, -1, res, er, lat, rises, badgaps, fin);
    check("rst_fresh_res", res, 2);
    check("rst_fresh_lat", lat, 3 + ref_ops(13) * OPLAT);

    // randomized cross-check
    for (int i = 0; i < 200; i++) begin
      int m, b, e, rr;
      m  = $urandom_range(0, 127) * 2 + 1;
      b  = $urandom_range(0, m - 1);
      e  = $urandom_range(0, 255);
      rr = 65536 % m;
      run_op(8'(b), 8'(e), 8'(m), 8'(rr), -1, res, er, lat, rises, badgaps, fin);
      check($sformatf("r%0d_done", i), fin, 1);
      check($sformatf("r%0d_res m=%0d b=%0d e=%0d", i, m, b, e), res, ref_modexp(b, e, m));
      check($sformatf("r%0d_err", i), er, 0);
      check($sformatf("r%0d_lat", i), lat, 3 + ref_ops(e) * OPLAT);
      check($sformatf("r%0d_ops", i), rises, ref_ops(e));
      check($sformatf("r%0d_gaps", i), badgaps, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
